// File: rtl/iommu_fq_writer.sv
// IOMMU fault-queue writer: packs fault events into 256-bit records and writes them
// as four 64-bit beats into the in-memory fault queue, then advances the tail.
module iommu_fq_writer #(
    parameter int unsigned FQ_IDX_W = 8,
    parameter int unsigned PPN_W    = 44
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fqen_i,
    input  logic                fqie_i,
    input  logic [PPN_W-1:0]    fqb_ppn_i,
    input  logic [4:0]          fqb_log2szm1_i,
    input  logic [FQ_IDX_W-1:0] fqh_i,
    input  logic                fqof_clr_i,
    input  logic                fqmf_clr_i,
    input  logic                fip_clr_i,
    input  logic                ev_valid_i,
    output logic                ev_ready_o,
    input  logic [11:0]         ev_cause_i,
    input  logic [5:0]          ev_ttyp_i,
    input  logic [23:0]         ev_did_i,
    input  logic [19:0]         ev_pid_i,
    input  logic                ev_pv_i,
    input  logic                ev_priv_i,
    input  logic [63:0]         ev_iotval_i,
    input  logic [63:0]         ev_iotval2_i,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [63:0]         mem_addr_o,
    output logic [63:0]         mem_wdata_o,
    output logic                mem_last_o,
    input  logic                mem_rvalid_i,
    input  logic                mem_rerr_i,
    output logic [FQ_IDX_W-1:0] fqt_o,
    output logic                fqof_o,
    output logic                fqmf_o,
    output logic                fip_o
);

    localparam int unsigned BaseW = PPN_W + 12;

    typedef enum logic [1:0] {StIdle, StWrite, StWaitResp} state_e;

    state_e              state_q;
    logic [1:0]          beat_q;
    logic [255:0]        rec_q;
    logic [BaseW-1:0]    base_q;
    logic [FQ_IDX_W-1:0] tail_q;
    logic [FQ_IDX_W-1:0] mask_q;
    logic                abort_q;
    logic [FQ_IDX_W-1:0] fqt_q;
    logic                fqof_q;
    logic                fqmf_q;
    logic                fip_q;
    logic                req_q;
    logic                last_q;
    logic                ready_q;

    logic [5:0]          log2sz;
    logic [FQ_IDX_W-1:0] sz_mask;
    logic [FQ_IDX_W-1:0] cur_tail;
    logic [FQ_IDX_W-1:0] cur_next;
    logic [FQ_IDX_W-1:0] resp_next;
    logic [255:0]        ev_rec;

    // Queue size mask from the live size field, saturated at the index width.
    always_comb begin
        log2sz = 6'(fqb_log2szm1_i) + 6'd1;
        if (log2sz > 6'(FQ_IDX_W)) begin
            log2sz = 6'(FQ_IDX_W);
        end
        sz_mask = '0;
        for (int unsigned i = 0; i < FQ_IDX_W; i++) begin
            sz_mask[i] = (6'(i) < log2sz);
        end
    end

    // Tail/next at accept use the current size; completion uses the size latched at accept.
    always_comb begin
        cur_tail  = fqt_q & sz_mask;
        cur_next  = (cur_tail + FQ_IDX_W'(1)) & sz_mask;
        resp_next = (tail_q + FQ_IDX_W'(1)) & mask_q;
    end

    // Record packing, LSB first; custom and reserved words are zero.
    always_comb begin
        ev_rec = {ev_iotval2_i, ev_iotval_i, 32'h0, 32'h0,
                  ev_did_i, ev_ttyp_i, ev_priv_i, ev_pv_i, ev_pid_i, ev_cause_i};
    end

    // Beat address/data derive only from registers, so they hold while a grant is pending.
    always_comb begin
        mem_addr_o  = 64'(base_q) + (64'(tail_q) << 5) + (64'(beat_q) << 3);
        mem_wdata_o = rec_q[{beat_q, 6'd0} +: 64];
    end

    // Main FSM; flag clears are applied first so a same-cycle set overrides them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            beat_q  <= '0;
            rec_q   <= '0;
            base_q  <= '0;
            tail_q  <= '0;
            mask_q  <= '0;
            abort_q <= 1'b0;
            fqt_q   <= '0;
            fqof_q  <= 1'b0;
            fqmf_q  <= 1'b0;
            fip_q   <= 1'b0;
            req_q   <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            if (fqof_clr_i) fqof_q <= 1'b0;
            if (fqmf_clr_i) fqmf_q <= 1'b0;
            if (fip_clr_i)  fip_q  <= 1'b0;

            case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    // Disabled or flagged queues silently drop the event.
                    if (ev_valid_i && ready_q && fqen_i && !fqof_q && !fqmf_q) begin
                        if (cur_next == fqh_i) begin
                            fqof_q <= 1'b1;
                        end else begin
                            rec_q   <= ev_rec;
                            base_q  <= {fqb_ppn_i, 12'h000};
                            tail_q  <= cur_tail;
                            mask_q  <= sz_mask;
                            beat_q  <= '0;
                            abort_q <= 1'b0;
                            req_q   <= 1'b1;
                            last_q  <= 1'b0;
                            ready_q <= 1'b0;
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (!fqen_i) abort_q <= 1'b1;
                    if (mem_gnt_i) begin
                        if (beat_q == 2'd3) begin
                            req_q   <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= StWaitResp;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                            last_q <= (beat_q == 2'd2);
                        end
                    end
                end
                StWaitResp: begin
                    if (!fqen_i) abort_q <= 1'b1;
                    if (mem_rvalid_i) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        if (mem_rerr_i) begin
                            fqmf_q <= 1'b1;
                        end else if (fqen_i && !abort_q) begin
                            fqt_q <= resp_next;
                            if (fqie_i) fip_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    last_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase

            // Disabling the queue resets the tail regardless of state.
            if (!fqen_i) fqt_q <= '0;
        end
    end

    assign ev_ready_o = ready_q;
    assign mem_req_o  = req_q;
    assign mem_last_o = last_q;
    assign fqt_o      = fqt_q;
    assign fqof_o     = fqof_q;
    assign fqmf_o     = fqmf_q;
    assign fip_o      = fip_q;

endmodule
